// File: rtl/im_loader.sv
// im_loader: boot-time program loader. Receives a framed byte stream
// (16-bit word count, big-endian data words, XOR checksum), writes the words
// to consecutive instruction-memory addresses and releases the CPU from
// reset only after a frame with a good checksum has been accepted.
module im_loader #(
  parameter int unsigned NMEM      = 20,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] im_add,
  output logic [31:0] im_data,
  output logic        im_en,
  output logic        im_rd_wr,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HDR_HI = 4'd1;
  localparam logic [3:0] S_HDR_LO = 4'd2;
  localparam logic [3:0] S_DATA   = 4'd3;
  localparam logic [3:0] S_WRITE  = 4'd4;
  localparam logic [3:0] S_CSUM   = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_ERR    = 4'd7;

  logic [3:0]  state;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [7:0]  acc;
  logic        xfer;
  logic [15:0] count_full;

  assign xfer       = in_valid && in_ready;
  assign count_full = {count[15:8], in_data};

  // Handshake and status outputs decode directly from the registered state.
  always_comb begin
    in_ready = 1'b0;
    im_en    = 1'b0;
    case (state)
      S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM: in_ready = 1'b1;
      S_WRITE:                            im_en    = 1'b1;
      default: ;
    endcase
    im_rd_wr = im_en;
    done     = (state == S_DONE);
    err      = (state == S_ERR);
    cpu_rst  = (state != S_DONE);
  end

  // Frame parser, word assembler and write-address sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      index    <= '0;
      byte_cnt <= '0;
      acc      <= '0;
      im_data  <= '0;
      im_add   <= BASE_ADDR;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            index    <= '0;
            byte_cnt <= '0;
            acc      <= '0;
            im_add   <= BASE_ADDR;
            state    <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            acc         <= acc ^ in_data;
            state       <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
            acc        <= acc ^ in_data;
            if (count_full == 16'd0 || count_full > 16'(NMEM))
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            im_data  <= {im_data[23:0], in_data};
            acc      <= acc ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3)
              state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // im_add holds BASE_ADDR+4*index during this cycle, then steps.
          index  <= index + 16'd1;
          im_add <= im_add + 32'd4;
          if (index + 16'd1 == count)
            state <= S_CSUM;
          else
            state <= S_DATA;
        end
        S_CSUM: begin
          if (xfer)
            state <= (in_data == acc) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: table-driven frames plus hand-written reset sequence.
// Two loaders share the stimulus: u0 at base 0x0, u1 at base 0x40.
// Expected writes are queued when a frame is launched and popped by a
// monitor on every im_en cycle.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready0, in_ready1;
  logic [31:0] im_add0, im_add1, im_data0, im_data1;
  logic        im_en0, im_en1, im_rd_wr0, im_rd_wr1;
  logic        cpu_rst0, cpu_rst1, done0, done1, err0, err1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] add;
    logic [31:0] data;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic [127:0] frame;
    int           len;
    bit           rnd;
    bit           exp_done;
    bit           exp_err;
  } vec_t;
  vec_t tbl[6];

  im_loader #(.NMEM(20), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .im_add(im_add0), .im_data(im_data0), .im_en(im_en0),
    .im_rd_wr(im_rd_wr0), .cpu_rst(cpu_rst0), .done(done0), .err(err0)
  );

  im_loader #(.NMEM(20), .BASE_ADDR(32'h0000_0040)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .im_add(im_add1), .im_data(im_data1), .im_en(im_en1),
    .im_rd_wr(im_rd_wr1), .cpu_rst(cpu_rst1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [127:0] f, input int i);
    return f[127-8*i -: 8];
  endfunction

  // Reference model: queue every write a frame with a legal count produces.
  task automatic push_model(input vec_t v);
    logic [15:0] n;
    n = {get_byte(v.frame, 0), get_byte(v.frame, 1)};
    if (n >= 16'd1 && n <= 16'd20) begin
      for (int w = 0; w < int'(n); w++) begin
        wr_t e;
        e.add  = 32'(4 * w);
        e.data = {get_byte(v.frame, 2+4*w), get_byte(v.frame, 3+4*w),
                  get_byte(v.frame, 4+4*w), get_byte(v.frame, 5+4*w)};
        q.push_back(e);
      end
    end
  endtask

  // Write monitor: every im_en cycle must match the head of the queue.
  always @(negedge clk) begin
    chk("rd_wr_vs_en", {31'd0, im_rd_wr0}, {31'd0, im_en0});
    if (im_en0) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual add=%h data=%h required=none", im_add0, im_data0);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_add0", im_add0, e.add);
        chk("wr_data0", im_data0, e.data);
        chk("wr_en1", {31'd0, im_en1}, 32'd1);
        chk("wr_add1", im_add1, e.add + 32'h40);
        chk("wr_data1", im_data1, e.data);
        chk("ready_in_write", {31'd0, in_ready0}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int guard = 0;
    if (rnd) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready0}, 32'd0);
    chk({tag, "_im_en"}, {31'd0, im_en0}, 32'd0);
    chk({tag, "_im_rd_wr"}, {31'd0, im_rd_wr0}, 32'd0);
    chk({tag, "_im_add0"}, im_add0, 32'h0);
    chk({tag, "_im_add1"}, im_add1, 32'h40);
    chk({tag, "_im_data"}, im_data0, 32'h0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst0}, 32'd1);
    chk({tag, "_done"}, {31'd0, done0}, 32'd0);
    chk({tag, "_err"}, {31'd0, err0}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    push_model(v);
    pulse_start();
    chk($sformatf("v%0d_start_done", id), {31'd0, done0}, 32'd0);
    chk($sformatf("v%0d_start_err", id), {31'd0, err0}, 32'd0);
    chk($sformatf("v%0d_start_cpu_rst", id), {31'd0, cpu_rst0}, 32'd1);
    for (int i = 0; i < v.len; i++)
      send_byte(get_byte(v.frame, i), v.rnd);
    chk($sformatf("v%0d_done", id), {31'd0, done0}, {31'd0, v.exp_done});
    chk($sformatf("v%0d_err", id), {31'd0, err0}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_cpu_rst", id), {31'd0, cpu_rst0}, {31'd0, !v.exp_done});
    chk($sformatf("v%0d_done1", id), {31'd0, done1}, {31'd0, v.exp_done});
    chk($sformatf("v%0d_in_ready", id), {31'd0, in_ready0}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_hold_done", id), {31'd0, done0}, {31'd0, v.exp_done});
    chk($sformatf("v%0d_hold_err", id), {31'd0, err0}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_queue_empty", id), q.size(), 32'd0);
  endtask

  initial begin
    tbl[0] = '{{88'h00_02_20_01_00_05_00_00_00_00_26, 40'h0}, 11, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{{88'h00_02_20_01_00_05_00_00_00_00_27, 40'h0}, 11, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{{16'h00_00, 112'h0}, 2, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{{16'h00_15, 112'h0}, 2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{{88'h00_02_20_01_00_05_00_00_00_00_26, 40'h0}, 11, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{{56'h00_01_AA_BB_CC_DD_01, 72'h0}, 7, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    for (int k = 0; k < 6; k++)
      run_vec(tbl[k], k);

    // Reset after six bytes: word 0 is already complete and gets written
    // in the cycle rst is raised; nothing of word 1 may be written.
    begin
      wr_t e;
      e.add  = 32'h0;
      e.data = 32'h2001_0005;
      q.push_back(e);
    end
    pulse_start();
    for (int i = 0; i < 6; i++)
      send_byte(get_byte(tbl[0].frame, i), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("midrst");
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_write", q.size(), 32'd0);
    chk("midrst_idle_ready", {31'd0, in_ready0}, 32'd0);
    run_vec(tbl[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
